bin_to_bcd_serial: RTL

Sequential binary-to-BCD converter that sits directly upstream of the seven-segment display controller. It accepts an unsigned binary count (score, timer, or counter value) through a valid/ready handshake and converts it with the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock. It holds a packed BCD word whose four nibbles are the decimal digits; the display controller decodes these directly, so it needs no divide/modulo logic.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_adjust.sv | 18 +
 rtl/bin_to_bcd_serial.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StConvert
  } state_e;

  localparam int unsigned DigitWidth = 4;

  // Largest value representable in the given number of decimal digits (10^digits - 1).
  function automatic int unsigned max_bcd_value(input int unsigned digits);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DigitWidth-1:0] i_digit,
  output logic [DigitWidth-1:0] o_digit
);

  // Inputs never exceed 9, so the result stays within 4 bits (max 12).
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with valid/ready input handshake and glitch-free registered BCD output.
module bin_to_bcd_serial
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 14,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                         clock_100Mhz,
  input  logic                         reset,
  input  logic [BIN_WIDTH-1:0]         bin_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DigitWidth*DIGITS-1:0] bcd_out,
  output logic                         overflow,
  output logic                         done,
  output logic                         busy
);

  localparam int unsigned BcdW   = DigitWidth * DIGITS;
  localparam int unsigned CntW   = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam int unsigned MaxVal = max_bcd_value(DIGITS);
  localparam logic [CntW-1:0]      LastCnt = CntW'(BIN_WIDTH - 1);
  localparam logic [BIN_WIDTH-1:0] SatVal  = BIN_WIDTH'(MaxVal);

  state_e              r_state;
  state_e              w_state_next;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [BcdW-1:0]      r_scratch;
  logic [CntW-1:0]      r_cnt;
  logic                 r_ovf_flag;
  logic [BcdW-1:0]      r_bcd_out;
  logic                 r_overflow;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_last;
  logic [31:0]          w_bin_ext;
  logic                 w_sat;
  logic [BIN_WIDTH-1:0] w_load;
  logic [BcdW-1:0]      w_adj;
  logic [BcdW-1:0]      w_scratch_shift;

  assign in_ready = (r_state == StIdle) && reset;
  assign busy     = (r_state == StConvert);
  assign bcd_out  = r_bcd_out;
  assign overflow = r_overflow;
  assign done     = r_done;

  // Inputs above the displayable range are clamped to all nines.
  assign w_bin_ext = 32'(bin_in);
  assign w_sat     = (w_bin_ext > MaxVal);
  assign w_load    = w_sat ? SatVal : bin_in;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adjust u_adjust (
      .i_digit(r_scratch[g*DigitWidth +: DigitWidth]),
      .o_digit(w_adj[g*DigitWidth +: DigitWidth])
    );
  end

  // Corrected scratch shifted left with the next binary MSB entering at the bottom.
  assign w_scratch_shift = {w_adj[BcdW-2:0], r_bin[BIN_WIDTH-1]};

  // Next-state decode: accept in idle, finish on the last iteration.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_valid && in_ready) begin
          w_accept     = 1'b1;
          w_state_next = StConvert;
        end
      end
      StConvert: begin
        if (r_cnt == LastCnt) begin
          w_last       = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: load on accept, iterate while converting, publish on completion only.
  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      r_bin      <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_flag <= 1'b0;
      r_bcd_out  <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_bin      <= w_load;
        r_ovf_flag <= w_sat;
        r_scratch  <= '0;
        r_cnt      <= '0;
      end else if (r_state == StConvert) begin
        r_scratch <= w_scratch_shift;
        r_bin     <= r_bin << 1;
        r_cnt     <= r_cnt + 1'b1;
        if (w_last) begin
          r_bcd_out  <= w_scratch_shift;
          r_overflow <= r_ovf_flag;
        end
      end
    end
  end

endmodule
